// File: rtl/bp_fe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_pkg
// Purpose  : Shared frontend types: scan classes and PC generator FSM states.
// Revision : 1.0
// ============================================================================
package bp_fe_pkg;

    typedef enum logic [2:0] {
        e_scan_none   = 3'd0,
        e_scan_branch = 3'd1,
        e_scan_jal    = 3'd2,
        e_scan_call   = 3'd3,
        e_scan_return = 3'd4
    } bp_fe_scan_class_e;

    typedef enum logic [1:0] {
        e_wait  = 2'd0,
        e_run   = 2'd1,
        e_drain = 2'd2
    } bp_fe_pc_gen_state_e;

    localparam int unsigned instr_bytes_lp = 4;

endpackage
`default_nettype wire

// File: rtl/bp_fe_ras.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_ras
// Purpose  : Circular return address stack; oldest entry overwritten when full.
// Revision : 1.0
// ============================================================================
module bp_fe_ras
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int ras_els_p        = 8,
    parameter int ras_ptr_width_lp = $clog2(ras_els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [vaddr_width_p-1:0]    push_data_i,
    input  logic                        restore_i,
    input  logic [ras_ptr_width_lp-1:0] restore_ptr_i,
    output logic [vaddr_width_p-1:0]    top_o,
    output logic [ras_ptr_width_lp-1:0] ptr_o,
    output logic [ras_ptr_width_lp:0]   cnt_o
);

    localparam logic [ras_ptr_width_lp:0] full_cnt_lp = (ras_ptr_width_lp + 1)'(ras_els_p);

    logic [vaddr_width_p-1:0]    mem_d [ras_els_p];
    logic [vaddr_width_p-1:0]    mem_q [ras_els_p];
    logic [ras_ptr_width_lp-1:0] ptr_d, ptr_q, wr_ptr;
    logic [ras_ptr_width_lp:0]   cnt_d, cnt_q;

    assign wr_ptr = ptr_q + ras_ptr_width_lp'(1);
    assign top_o  = mem_q[ptr_q];
    assign ptr_o  = ptr_q;
    assign cnt_o  = cnt_q;

    // A checkpoint restore only moves the pointer; count and contents are left as-is.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (restore_i) begin
            ptr_d = restore_ptr_i;
        end else if (push_i) begin
            mem_d[wr_ptr] = push_data_i;
            ptr_d         = wr_ptr;
            if (cnt_q != full_cnt_lp) begin
                cnt_d = cnt_q + (ras_ptr_width_lp + 1)'(1);
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - ras_ptr_width_lp'(1);
            cnt_d = cnt_q - (ras_ptr_width_lp + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_fe_pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_pc_gen_ras
// Purpose  : Next-PC generator with return address stack and redirect drain.
// Revision : 1.0
// ============================================================================
module bp_fe_pc_gen_ras
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int ras_els_p        = 8,
    parameter int ras_ptr_width_lp = $clog2(ras_els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        redirect_v_i,
    input  logic [vaddr_width_p-1:0]    redirect_pc_i,
    input  logic [ras_ptr_width_lp-1:0] redirect_ras_ptr_i,
    input  logic                        redirect_ras_restore_i,
    output logic                        fetch_v_o,
    output logic [vaddr_width_p-1:0]    fetch_pc_o,
    input  logic                        fetch_ready_i,
    input  logic                        resp_v_i,
    input  logic                        resp_fault_i,
    input  bp_fe_scan_class_e           resp_class_i,
    input  logic [vaddr_width_p-1:0]    resp_imm_i,
    input  logic                        resp_taken_i,
    output logic                        instr_v_o,
    output logic [vaddr_width_p-1:0]    instr_pc_o,
    output logic [ras_ptr_width_lp-1:0] instr_ras_ptr_o
);

    bp_fe_pc_gen_state_e         state_d, state_q;
    logic                        pending_d, pending_q;
    logic [vaddr_width_p-1:0]    pc_d, pc_q;
    logic [vaddr_width_p-1:0]    pc_if_d, pc_if_q;
    logic [vaddr_width_p-1:0]    seq_pc, tgt_pc, resp_pc, next_pc, ras_top;
    logic [ras_ptr_width_lp-1:0] ras_ptr;
    logic [ras_ptr_width_lp:0]   ras_cnt;
    logic                        ras_hit, resp_accept, ras_push, ras_pop, fetch_v;

    assign seq_pc      = pc_if_q + vaddr_width_p'(instr_bytes_lp);
    assign tgt_pc      = pc_if_q + resp_imm_i;
    assign ras_hit     = (ras_cnt != '0);
    // A same-cycle redirect wins over the response, so the RAS is untouched.
    assign resp_accept = resp_v_i & ~resp_fault_i & (state_q == e_run) & ~redirect_v_i;
    assign ras_push    = resp_accept & (resp_class_i == e_scan_call);
    assign ras_pop     = resp_accept & (resp_class_i == e_scan_return) & ras_hit;

    assign instr_v_o       = resp_accept;
    assign instr_pc_o      = pc_if_q;
    assign instr_ras_ptr_o = ras_ptr;
    assign fetch_v_o       = fetch_v;
    assign fetch_pc_o      = next_pc;

    bp_fe_ras #(
        .vaddr_width_p   (vaddr_width_p),
        .ras_els_p       (ras_els_p),
        .ras_ptr_width_lp(ras_ptr_width_lp)
    ) u_ras (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .push_i       (ras_push),
        .pop_i        (ras_pop),
        .push_data_i  (seq_pc),
        .restore_i    (redirect_v_i & redirect_ras_restore_i),
        .restore_ptr_i(redirect_ras_ptr_i),
        .top_o        (ras_top),
        .ptr_o        (ras_ptr),
        .cnt_o        (ras_cnt)
    );

    always_comb begin
        case (resp_class_i)
            e_scan_return:          resp_pc = ras_hit ? ras_top : seq_pc;
            e_scan_jal, e_scan_call: resp_pc = tgt_pc;
            e_scan_branch:          resp_pc = resp_taken_i ? tgt_pc : seq_pc;
            default:                resp_pc = seq_pc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pc_d      = pc_q;
        pc_if_d   = pc_if_q;
        next_pc   = pc_q;
        fetch_v   = 1'b0;
        case (state_q)
            e_wait: begin
                if (redirect_v_i) begin
                    pc_d      = redirect_pc_i;
                    pending_d = 1'b0;
                    state_d   = e_run;
                end
            end
            e_run: begin
                if (redirect_v_i) begin
                    next_pc = redirect_pc_i;
                    if (pending_q && !resp_v_i) begin
                        state_d = e_drain;
                    end else begin
                        fetch_v = 1'b1;
                    end
                end else if (resp_v_i && resp_fault_i) begin
                    state_d   = e_wait;
                    pending_d = 1'b0;
                end else begin
                    if (resp_v_i) begin
                        next_pc = resp_pc;
                    end
                    fetch_v = ~pending_q | resp_v_i;
                end
                // pc_q keeps the unissued PC so a stalled request stays stable.
                pc_d = next_pc;
                if (fetch_v && fetch_ready_i) begin
                    pending_d = 1'b1;
                    pc_if_d   = next_pc;
                end else if (resp_v_i) begin
                    pending_d = 1'b0;
                end
            end
            e_drain: begin
                if (redirect_v_i) begin
                    pc_d = redirect_pc_i;
                end
                if (resp_v_i) begin
                    pending_d = 1'b0;
                    state_d   = e_run;
                end
            end
            default: begin
                state_d   = e_wait;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_wait;
            pending_q <= 1'b0;
            pc_q      <= '0;
            pc_if_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            pc_if_q   <= pc_if_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_pc_gen_ras
// Purpose  : Cycle-vector table with an instruction scoreboard for the PC gen.
// Revision : 1.0
// ============================================================================
module tb_bp_fe_pc_gen_ras;
    import bp_fe_pkg::*;

    localparam int VW = 39;
    localparam int RE = 4;
    localparam int PW = 2;
    typedef logic [VW-1:0] addr_t;

    logic              clk;
    logic              reset_n_i;
    logic              redirect_v_i;
    addr_t             redirect_pc_i;
    logic [PW-1:0]     redirect_ras_ptr_i;
    logic              redirect_ras_restore_i;
    logic              fetch_v_o;
    addr_t             fetch_pc_o;
    logic              fetch_ready_i;
    logic              resp_v_i;
    logic              resp_fault_i;
    bp_fe_scan_class_e resp_class_i;
    addr_t             resp_imm_i;
    logic              resp_taken_i;
    logic              instr_v_o;
    addr_t             instr_pc_o;
    logic [PW-1:0]     instr_ras_ptr_o;

    bp_fe_pc_gen_ras #(
        .vaddr_width_p(VW),
        .ras_els_p    (RE)
    ) dut (
        .clk_i                 (clk),
        .reset_n_i             (reset_n_i),
        .redirect_v_i          (redirect_v_i),
        .redirect_pc_i         (redirect_pc_i),
        .redirect_ras_ptr_i    (redirect_ras_ptr_i),
        .redirect_ras_restore_i(redirect_ras_restore_i),
        .fetch_v_o             (fetch_v_o),
        .fetch_pc_o            (fetch_pc_o),
        .fetch_ready_i         (fetch_ready_i),
        .resp_v_i              (resp_v_i),
        .resp_fault_i          (resp_fault_i),
        .resp_class_i          (resp_class_i),
        .resp_imm_i            (resp_imm_i),
        .resp_taken_i          (resp_taken_i),
        .instr_v_o             (instr_v_o),
        .instr_pc_o            (instr_pc_o),
        .instr_ras_ptr_o       (instr_ras_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rv; addr_t rpc; logic rrs; logic [PW-1:0] rptr;
        logic rdy; logic resp; logic flt; bp_fe_scan_class_e cls; addr_t imm; logic tk;
        logic efv; addr_t epc; logic eiv; addr_t eipc; logic [PW-1:0] eiptr;
    } vec_t;

    typedef struct {
        addr_t pc; logic [PW-1:0] ptr;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t vv(logic rv, addr_t rpc, logic rrs, logic [PW-1:0] rptr,
                                logic rdy, logic resp, logic flt, bp_fe_scan_class_e cls,
                                addr_t imm, logic tk, logic efv, addr_t epc,
                                logic eiv, addr_t eipc, logic [PW-1:0] eiptr);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rrs = rrs; v.rptr = rptr;
        v.rdy = rdy; v.resp = resp; v.flt = flt; v.cls = cls; v.imm = imm; v.tk = tk;
        v.efv = efv; v.epc = epc; v.eiv = eiv; v.eipc = eipc; v.eiptr = eiptr;
        return v;
    endfunction

    function automatic vec_t rd(addr_t pc, logic rdy, logic efv, addr_t epc);
        return vv(1'b1, pc, 1'b0, '0, rdy, 1'b0, 1'b0, e_scan_none, '0, 1'b0, efv, epc, 1'b0, '0, '0);
    endfunction

    function automatic vec_t id(logic rdy, logic efv, addr_t epc);
        return vv(1'b0, '0, 1'b0, '0, rdy, 1'b0, 1'b0, e_scan_none, '0, 1'b0, efv, epc, 1'b0, '0, '0);
    endfunction

    function automatic vec_t rs(logic rdy, bp_fe_scan_class_e cls, addr_t imm, logic tk,
                                addr_t epc, addr_t eipc, logic [PW-1:0] eiptr);
        return vv(1'b0, '0, 1'b0, '0, rdy, 1'b1, 1'b0, cls, imm, tk, 1'b1, epc, 1'b1, eipc, eiptr);
    endfunction

    // Redirect to base (fetch issued that cycle), then its response.
    function automatic void cls_pair(addr_t base, bp_fe_scan_class_e c, addr_t imm, logic tk,
                                     addr_t exp, logic [PW-1:0] ptr);
        vecs.push_back(rd(base, 1'b1, 1'b1, base));
        vecs.push_back(rs(1'b0, c, imm, tk, exp, base, ptr));
    endfunction

    task automatic apply(int idx, vec_t v);
        sb_t e;
        redirect_v_i           = v.rv;
        redirect_pc_i          = v.rpc;
        redirect_ras_restore_i = v.rrs;
        redirect_ras_ptr_i     = v.rptr;
        fetch_ready_i          = v.rdy;
        resp_v_i               = v.resp;
        resp_fault_i           = v.flt;
        resp_class_i           = v.cls;
        resp_imm_i             = v.imm;
        resp_taken_i           = v.tk;
        if (v.eiv) begin
            e.pc  = v.eipc;
            e.ptr = v.eiptr;
            sb.push_back(e);
        end
        @(negedge clk);
        check($sformatf("v%0d fetch_v", idx), 64'(fetch_v_o), 64'(v.efv));
        if (v.efv) check($sformatf("v%0d fetch_pc", idx), 64'(fetch_pc_o), 64'(v.epc));
        check($sformatf("v%0d instr_v", idx), 64'(instr_v_o), 64'(v.eiv));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n_i && instr_v_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_instr: got pc 0x%0h expected no instruction", instr_pc_o);
            end else begin
                mon_e = sb.pop_front();
                check("sb_instr_pc", 64'(instr_pc_o), 64'(mon_e.pc));
                check("sb_instr_ras_ptr", 64'(instr_ras_ptr_o), 64'(mon_e.ptr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_i = 1'b0; redirect_v_i = 1'b0; redirect_pc_i = '0; redirect_ras_ptr_i = '0;
        redirect_ras_restore_i = 1'b0; fetch_ready_i = 1'b0; resp_v_i = 1'b0; resp_fault_i = 1'b0;
        resp_class_i = e_scan_none; resp_imm_i = '0; resp_taken_i = 1'b0;
        #3;
        check("rst fetch_v", 64'(fetch_v_o), 64'd0);
        check("rst fetch_pc", 64'(fetch_pc_o), 64'd0);
        check("rst instr_v", 64'(instr_v_o), 64'd0);
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;

        // boot, sequential fetch, stall
        vecs.push_back(rd(39'h100, 1'b0, 1'b0, '0));
        vecs.push_back(id(1'b0, 1'b1, 39'h100));
        vecs.push_back(rd(39'h1000, 1'b1, 1'b1, 39'h1000));
        vecs.push_back(rs(1'b1, e_scan_none, '0, 1'b0, 39'h1004, 39'h1000, 2'd0));
        vecs.push_back(rs(1'b0, e_scan_none, '0, 1'b0, 39'h1008, 39'h1004, 2'd0));
        for (int k = 0; k < 3; k++) vecs.push_back(id(1'b0, 1'b1, 39'h1008));
        vecs.push_back(id(1'b1, 1'b1, 39'h1008));
        vecs.push_back(rs(1'b0, e_scan_none, '0, 1'b0, 39'h100C, 39'h1008, 2'd0));
        // scan class targets, including address wrap
        cls_pair(39'h1100, e_scan_branch, 39'h40, 1'b0, 39'h1104, 2'd0);
        cls_pair(39'h1100, e_scan_branch, 39'h40, 1'b1, 39'h1140, 2'd0);
        cls_pair(39'h1200, e_scan_jal, 39'h7F_FFFF_FFF8, 1'b0, 39'h11F8, 2'd0);
        cls_pair(39'h1300, e_scan_return, '0, 1'b0, 39'h1304, 2'd0);
        cls_pair(39'h7F_FFFF_FFFC, e_scan_none, '0, 1'b0, 39'h0, 2'd0);
        cls_pair(39'h7F_FFFF_FFF0, e_scan_jal, 39'h20, 1'b0, 39'h10, 2'd0);
        // call then return
        cls_pair(39'h2000, e_scan_call, 39'h100, 1'b0, 39'h2100, 2'd0);
        vecs.push_back(id(1'b1, 1'b1, 39'h2100));
        vecs.push_back(rs(1'b0, e_scan_return, '0, 1'b0, 39'h2004, 39'h2100, 2'd1));
        // five nested calls into a four-entry stack, then five returns
        vecs.push_back(rd(39'h4000, 1'b1, 1'b1, 39'h4000));
        vecs.push_back(rs(1'b1, e_scan_call, 39'h100, 1'b0, 39'h4100, 39'h4000, 2'd0));
        vecs.push_back(rs(1'b1, e_scan_call, 39'h100, 1'b0, 39'h4200, 39'h4100, 2'd1));
        vecs.push_back(rs(1'b1, e_scan_call, 39'h100, 1'b0, 39'h4300, 39'h4200, 2'd2));
        vecs.push_back(rs(1'b1, e_scan_call, 39'h100, 1'b0, 39'h4400, 39'h4300, 2'd3));
        vecs.push_back(rs(1'b1, e_scan_call, 39'h100, 1'b0, 39'h4500, 39'h4400, 2'd0));
        vecs.push_back(rs(1'b1, e_scan_return, '0, 1'b0, 39'h4404, 39'h4500, 2'd1));
        vecs.push_back(rs(1'b1, e_scan_return, '0, 1'b0, 39'h4304, 39'h4404, 2'd0));
        vecs.push_back(rs(1'b1, e_scan_return, '0, 1'b0, 39'h4204, 39'h4304, 2'd3));
        vecs.push_back(rs(1'b1, e_scan_return, '0, 1'b0, 39'h4104, 39'h4204, 2'd2));
        vecs.push_back(rs(1'b0, e_scan_return, '0, 1'b0, 39'h4108, 39'h4104, 2'd1));
        // pointer restore, then a call response overridden by a redirect
        vecs.push_back(vv(1'b1, 39'h5000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, e_scan_none, '0, 1'b0,
                          1'b1, 39'h5000, 1'b0, '0, '0));
        vecs.push_back(vv(1'b1, 39'h6000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, e_scan_call, 39'h10, 1'b0,
                          1'b1, 39'h6000, 1'b0, '0, '0));
        vecs.push_back(rs(1'b0, e_scan_return, '0, 1'b0, 39'h6004, 39'h6000, 2'd3));
        // redirect with a fetch pending: drain the stale response
        vecs.push_back(id(1'b1, 1'b1, 39'h6004));
        vecs.push_back(rd(39'h3000, 1'b1, 1'b0, '0));
        vecs.push_back(id(1'b1, 1'b0, '0));
        vecs.push_back(vv(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, e_scan_none, '0, 1'b0,
                          1'b0, '0, 1'b0, '0, '0));
        vecs.push_back(id(1'b1, 1'b1, 39'h3000));
        vecs.push_back(rs(1'b0, e_scan_none, '0, 1'b0, 39'h3004, 39'h3000, 2'd3));
        // faulting response parks the generator until the next redirect
        vecs.push_back(id(1'b1, 1'b1, 39'h3004));
        vecs.push_back(vv(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1, e_scan_none, '0, 1'b0,
                          1'b0, '0, 1'b0, '0, '0));
        vecs.push_back(id(1'b1, 1'b0, '0));
        vecs.push_back(id(1'b1, 1'b0, '0));
        vecs.push_back(rd(39'h7000, 1'b1, 1'b0, '0));
        vecs.push_back(id(1'b1, 1'b1, 39'h7000));
        vecs.push_back(rs(1'b0, e_scan_none, '0, 1'b0, 39'h7004, 39'h7000, 2'd3));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // asynchronous reset in the middle of a run
        resp_v_i      = 1'b1;
        resp_class_i  = e_scan_none;
        fetch_ready_i = 1'b1;
        #2;
        reset_n_i = 1'b0;
        #1;
        check("midrst fetch_v", 64'(fetch_v_o), 64'd0);
        check("midrst fetch_pc", 64'(fetch_pc_o), 64'd0);
        check("midrst instr_v", 64'(instr_v_o), 64'd0);
        check("midrst instr_pc", 64'(instr_pc_o), 64'd0);
        check("midrst instr_ras_ptr", 64'(instr_ras_ptr_o), 64'd0);
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        resp_v_i  = 1'b0;
        apply(1000, rd(39'h8000_0000, 1'b0, 1'b0, '0));
        apply(1001, id(1'b0, 1'b1, 39'h8000_0000));

        check("sb_leftover", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_fe_pc_gen_ras.md
# bp_fe_pc_gen_ras

Parametrised next-PC generator for the frontend: it issues one fetch PC at a time to the I$/ITLB, consumes scanned fetch responses, and forwards fetched instructions to the FE queue interface. It sits between the FE command decode and the fetch memory port. Over the single-cycle PC generator it adds a parametrised circular return address stack (RAS) with pointer checkpoints carried in branch metadata. It also adds a drain state that discards a stale in-flight response after a redirect.

## Interface
Parameters:
- vaddr_width_p, 39, virtual address width
- ras_els_p, 8, RAS entries; power of two, >= 2
- ras_ptr_width_lp, `BSG_SAFE_CLOG2(ras_els_p)`, derived

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- redirect_v_i  in  1  redirect/boot command, always accepted
- redirect_pc_i  in  vaddr_width_p  new PC
- redirect_ras_ptr_i  in  ras_ptr_width_lp  RAS checkpoint restore
- redirect_ras_restore_i  in  1  apply the checkpoint (mispredict); 0 = keep RAS (trap/boot)
- fetch_v_o  out  1  fetch request valid
- fetch_pc_o  out  vaddr_width_p  fetch PC
- fetch_ready_i  in  1  fetch accepted when fetch_v_o & fetch_ready_i
- resp_v_i  in  1  response for the outstanding fetch
- resp_fault_i  in  1  fault/ITLB miss on the response
- resp_class_i  in  bp_fe_scan_class_e  none/branch/jal/call/return
- resp_imm_i  in  vaddr_width_p  sign-extended target offset
- resp_taken_i  in  1  BHT prediction for a branch
- instr_v_o  out  1  accepted response, one cycle pulse
- instr_pc_o  out  vaddr_width_p  PC of that response
- instr_ras_ptr_o  out  ras_ptr_width_lp  RAS top pointer before this instruction's update

## Operation
- States: e_wait, e_run, e_drain. After reset: e_wait, pending_r=0, ras_ptr_r=0, ras_cnt_r=0, all outputs 0.
- e_wait: fetch_v_o=0. redirect_v_i loads pc_r=redirect_pc_i and enters e_run.
- e_run: fetch_v_o = ~pending_r | resp_v_i. A fetch handshake sets pending_r. A response without a new handshake clears pending_r.
- Next fetch PC, in priority order:
  - redirect_pc_i on redirect_v_i
  - RAS top on return with ras_cnt_r>0
  - pc_if + imm on jal, call, or branch & resp_taken_i
  - pc_if + 4 on any other response
  - otherwise held pc_r, stable while fetch_v_o & ~fetch_ready_i
- Call pushes pc_if+4 at ras_ptr_r+1 (mod ras_els_p). When full, it overwrites the oldest entry; ras_cnt_r saturates at ras_els_p.
- Return with ras_cnt_r>0 pops. Return with ras_cnt_r=0 predicts pc_if+4 and leaves the stack unchanged.
- Address arithmetic is modulo 2^vaddr_width_p; carry-out is dropped.
- instr_v_o = resp_v_i & ~resp_fault_i & state==e_run & ~redirect_v_i.
- resp_fault_i: response is dropped, state goes to e_wait, pending_r is cleared.
- redirect_v_i in e_run:
  - pending_r=0, or resp_v_i in the same cycle: the redirect PC is issued the same cycle and the response is dropped.
  - pending_r=1 and no resp_v_i: state goes to e_drain with the redirect PC latched.
- e_drain: fetch_v_o=0. The next resp_v_i is discarded, then state returns to e_run. A further redirect in e_drain overwrites the latched PC.
- redirect_ras_restore_i sets ras_ptr_r=redirect_ras_ptr_i; ras_cnt_r is unchanged, and stack contents are not repaired.
- When a call or return response and a redirect occur in the same cycle, the redirect wins and the RAS is not updated by the response.

## Timing
- Reset is asynchronous on assertion. Leaving reset requires a synchronous deassert supplied externally.
- Redirect to fetch_v_o in the same cycle (e_run) or in the cycle after (from e_wait).
- Response to next fetch_v_o is combinational: back-to-back fetches are possible when the response returns the cycle after issue.
- At most one fetch is outstanding. The RAS write is visible to a return response in the next cycle.

## Structure
- bp_fe_pkg: add bp_fe_scan_class_e (e_scan_none, e_scan_branch, e_scan_jal, e_scan_call, e_scan_return) and the FSM state enum bp_fe_pc_gen_state_e.
- Sub-module bp_fe_ras:
  - ports: push/pop, push data, restore pointer, top data, pointer, count
  - storage is flops; parametrised by ras_els_p and vaddr_width_p.

## Test plan
- Reset mid-run → all outputs 0 immediately, state e_wait. Redirect to 0x8000_0000 → fetch_v_o=1 with fetch_pc_o=0x8000_0000 the next cycle.
- Sequential fetch at 0x1000 with a response every cycle → PCs 0x1004 and 0x1008. With fetch_ready_i low for 3 cycles, fetch_pc_o is held at 0x1008.
- Call at 0x2000 (imm 0x100) → fetch 0x2100; return response → fetch 0x2004, instr_ras_ptr_o=1.
- ras_els_p=4: 5 nested calls, then 5 returns → the first 4 returns predict the newest 4 return addresses and the 5th predicts pc+4.
- Redirect to 0x3000 with a fetch pending → e_drain, fetch_v_o=0; the next response is discarded (instr_v_o=0) and 0x3000 is issued the following cycle.
- resp_fault_i=1 → instr_v_o=0, e_wait, fetch_v_o=0 until the next redirect.
